// File: rtl/prog_master_if.sv
// Request/status bundle between a configuration controller and prog_master.
// start and drst_req are single-cycle pulses acted on only while busy is low.
// There is no ready signal: a pulse seen while busy is high is dropped, and
// done pulses for one cycle when an operation finishes.
interface prog_master_if #(
    parameter int NUM_BITS = 111,
    parameter int DIV_W    = 8
);
    logic                start;
    logic                drst_req;
    logic [NUM_BITS-1:0] data;
    logic [DIV_W-1:0]    div;
    logic                sdi;
    logic                sclk;
    logic                cs;
    logic                busy;
    logic                done;

    modport master (
        output start, drst_req, data, div,
        input  sdi, sclk, cs, busy, done
    );

    modport slave (
        input  start, drst_req, data, div,
        output sdi, sclk, cs, busy, done
    );
endinterface

// File: rtl/prog_master.sv
// Serial configuration-frame master: shifts a NUM_BITS word out LSB first on
// SDI/SCLK under CS, or issues a digital-reset pulse (SCLK high with CS high).
module prog_master #(
    parameter int NUM_BITS = 111,
    parameter int DIV_W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_master_if.slave   bus,
    output logic [2:0]     state_dbg
);
    localparam int BC_W = $clog2(NUM_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SCLK_HI = 3'd2,
        S_SCLK_LO = 3'd3,
        S_LATCH   = 3'd4,
        S_DRST    = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [DIV_W:0]      cnt;
    logic [DIV_W:0]      term;
    logic                tc;
    logic [DIV_W-1:0]    div_q;
    logic [BC_W-1:0]     bit_cnt;
    logic [NUM_BITS-1:0] shreg;

    logic cs_q, sclk_q, sdi_q, busy_q, done_q;
    logic cs_n, sclk_n, sdi_n, busy_n, done_n;

    // DRST holds SCLK high for two half-periods; the extra counter bit keeps
    // 2*(DIV+1) representable when DIV is all-ones.
    assign term = (state == S_DRST) ? {div_q, 1'b1} : {1'b0, div_q};
    assign tc   = (cnt == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.start)         state_n = S_SETUP;
                else if (bus.drst_req) state_n = S_DRST;
            end
            S_SETUP:   if (tc) state_n = S_SCLK_HI;
            S_SCLK_HI: if (tc) state_n = S_SCLK_LO;
            S_SCLK_LO: begin
                if (tc) state_n = (bit_cnt == BC_W'(NUM_BITS)) ? S_LATCH : S_SCLK_HI;
            end
            S_LATCH:   if (tc) state_n = S_IDLE;
            S_DRST:    if (tc) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Output values are computed for the state being entered and registered,
    // so every pin comes straight from a flop.
    always_comb begin
        cs_n   = 1'b1;
        sclk_n = 1'b0;
        sdi_n  = 1'b0;
        busy_n = 1'b1;
        done_n = 1'b0;
        case (state_n)
            S_IDLE: begin
                busy_n = 1'b0;
                done_n = (state != S_IDLE);
            end
            S_SETUP: begin
                cs_n  = 1'b0;
                sdi_n = (state == S_IDLE) ? bus.data[0] : sdi_q;
            end
            S_SCLK_HI: begin
                cs_n   = 1'b0;
                sclk_n = 1'b1;
                sdi_n  = sdi_q;
            end
            S_SCLK_LO: begin
                cs_n  = 1'b0;
                sdi_n = (state == S_SCLK_HI) ? shreg[1] : sdi_q;
            end
            S_LATCH: cs_n = 1'b1;
            S_DRST:  sclk_n = 1'b1;
            default: busy_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_q   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (state_n != state)     cnt <= '0;
            else if (state != S_IDLE) cnt <= cnt + (DIV_W+1)'(1);

            if (state == S_IDLE && bus.start) begin
                shreg   <= bus.data;
                bit_cnt <= '0;
                div_q   <= bus.div;
            end else if (state == S_IDLE && bus.drst_req) begin
                div_q   <= bus.div;
            end else if (state == S_SCLK_HI && tc) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BC_W'(1);
            end

            cs_q   <= cs_n;
            sclk_q <= sclk_n;
            sdi_q  <= sdi_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign bus.cs    = cs_q;
    assign bus.sclk  = sclk_q;
    assign bus.sdi   = sdi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_prog_master.sv
// Bench for prog_master: random frames checked by a receiving-programmer
// model that watches the serial pins and counts timing per phase.
module tb_prog_master;
    localparam int NB = 111;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    prog_master_if #(.NUM_BITS(NB), .DIV_W(DW)) bus ();

    prog_master #(.NUM_BITS(NB), .DIV_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // programmer model and timing observer
    int            exp_h;
    int            cyc = 0;
    int            rises, cs_low, sclk_hi_cs, sdi_cs_hi, done_cnt, latches;
    int            bad_phase, sdi_edge_bad, run, done_cyc, cs_rise_cyc;
    logic [NB-1:0] word, latched;
    logic          prev_cs, prev_sclk, prev_sdi;

    task automatic clear_mon();
        rises = 0; cs_low = 0; sclk_hi_cs = 0; sdi_cs_hi = 0; done_cnt = 0;
        latches = 0; bad_phase = 0; sdi_edge_bad = 0; run = 0;
        done_cyc = 0; cs_rise_cyc = 0;
        word = '0; latched = '0;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_sdi = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!bus.cs) cs_low++;
        if (bus.cs && bus.sclk) sclk_hi_cs++;
        if (bus.cs && bus.sdi) sdi_cs_hi++;
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (!bus.cs && prev_cs) word = '0;
        if (!bus.cs && bus.sclk && !prev_sclk) begin
            rises++;
            word = {bus.sdi, word[NB-1:1]};
            if (bus.sdi !== prev_sdi) sdi_edge_bad++;
        end
        if (bus.cs && !prev_cs) begin latched = word; latches++; cs_rise_cyc = cyc; end
        if (bus.cs == prev_cs && bus.sclk == prev_sclk) run++;
        else begin
            if (!prev_cs && run != exp_h) bad_phase++;
            run = 1;
        end
        prev_cs = bus.cs; prev_sclk = bus.sclk; prev_sdi = bus.sdi;
    end

    function automatic logic [NB-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[NB-1:0];
    endfunction

    task automatic send_req(input logic [NB-1:0] d, input logic [DW-1:0] dv,
                            input logic st, input logic dr);
        @(posedge clk); #1;
        bus.data = d; bus.div = dv; bus.start = st; bus.drst_req = dr;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.drst_req = 1'b0;
        bus.data = rand_word(); bus.div = DW'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > 0) begin timed_out = 1'b0; break; end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [NB-1:0] d, input int h);
        n_cmp++; if (latched !== d) begin n_bad++; $display("FAIL %s_word: got %h want %h", tag, latched, d); end
        n_cmp++; if (rises != NB) begin n_bad++; $display("FAIL %s_rises: got %0d want %0d", tag, rises, NB); end
        n_cmp++; if (cs_low != (1 + 2*NB)*h) begin n_bad++; $display("FAIL %s_cs_low: got %0d want %0d", tag, cs_low, (1 + 2*NB)*h); end
        n_cmp++; if (bad_phase != 0) begin n_bad++; $display("FAIL %s_phase: got %0d bad phases want 0", tag, bad_phase); end
        n_cmp++; if (sdi_edge_bad != 0) begin n_bad++; $display("FAIL %s_sdi_at_rise: got %0d want 0", tag, sdi_edge_bad); end
        n_cmp++; if (sdi_cs_hi != 0 || sclk_hi_cs != 0) begin n_bad++; $display("FAIL %s_idle_pins: got sdi %0d sclk %0d want 0 0", tag, sdi_cs_hi, sclk_hi_cs); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_cnt: got %0d want 1", tag, done_cnt); end
        n_cmp++; if (done_cyc - cs_rise_cyc != h) begin n_bad++; $display("FAIL %s_latch_len: got %0d want %0d", tag, done_cyc - cs_rise_cyc, h); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %b want 0", tag, bus.busy); end
    endtask

    task automatic test_reset();
        logic [NB-1:0] d;
        bit to;
        exp_h = 1; clear_mon();
        bus.start = 1'b0; bus.drst_req = 1'b0; bus.data = '0; bus.div = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({bus.cs, bus.sclk, bus.sdi, bus.busy, bus.done} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_pins: got %b want 10000", {bus.cs, bus.sclk, bus.sdi, bus.busy, bus.done}); end
        d = rand_word();
        rst_n = 1'b1; bus.data = d; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_first_start: got busy %b want 1", bus.busy); end
        wait_done(400, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL reset_frame_timeout: got no done want done"); end
        check_frame("first", d, 1);
    endtask

    task automatic test_div0_single();
        bit to;
        exp_h = 1; clear_mon();
        send_req({{(NB-1){1'b0}}, 1'b1}, 8'd0, 1'b1, 1'b0);
        wait_done(400, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL div0_timeout: got no done want done"); end
        check_frame("div0", {{(NB-1){1'b0}}, 1'b1}, 1);
    endtask

    task automatic test_random_frames();
        logic [NB-1:0] d;
        logic [DW-1:0] dv;
        bit to;
        for (int i = 0; i < 4; i++) begin
            dv = (i == 0) ? DW'(3) : DW'($urandom_range(0, 5));
            d = rand_word();
            exp_h = int'(dv) + 1; clear_mon();
            send_req(d, dv, 1'b1, 1'b0);
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rand_busy: got %b want 1", bus.busy); end
            wait_done(2000, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rand_timeout: got no done want done (div %0d)", dv); end
            check_frame("rand", d, exp_h);
        end
    endtask

    task automatic test_start_drst_together();
        logic [NB-1:0] d;
        bit to;
        d = rand_word();
        exp_h = 3; clear_mon();
        send_req(d, 8'd2, 1'b1, 1'b1);
        repeat (30) @(posedge clk);
        send_req(rand_word(), 8'd0, 1'b1, 1'b1);
        wait_done(2000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL both_timeout: got no done want done"); end
        repeat (20) @(posedge clk);
        #1;
        check_frame("both", d, 3);
    endtask

    task automatic test_drst();
        logic [NB-1:0] d;
        bit to;
        exp_h = 2; clear_mon();
        send_req('0, 8'd1, 1'b0, 1'b1);
        wait_done(50, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL drst_timeout: got no done want done"); end
        n_cmp++; if (sclk_hi_cs != 4) begin n_bad++; $display("FAIL drst_sclk_len: got %0d want 4", sclk_hi_cs); end
        n_cmp++; if (cs_low != 0 || sdi_cs_hi != 0) begin n_bad++; $display("FAIL drst_cs_sdi: got cs_low %0d sdi_hi %0d want 0 0", cs_low, sdi_cs_hi); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL drst_done_cnt: got %0d want 1", done_cnt); end
        d = rand_word();
        exp_h = 2; clear_mon();
        send_req(d, 8'd1, 1'b1, 1'b0);
        wait_done(1000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL post_drst_timeout: got no done want done"); end
        check_frame("post_drst", d, 2);
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] d;
        bit to;
        bit reached;
        exp_h = 1; clear_mon();
        send_req(rand_word(), 8'd0, 1'b1, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rises >= 50) begin reached = 1'b1; break; end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL midrst_reach: got %0d rises want 50", rises); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.cs, bus.sclk, bus.sdi, bus.busy, bus.done} !== 5'b10000) begin
            n_bad++; $display("FAIL midrst_pins: got %b want 10000", {bus.cs, bus.sclk, bus.sdi, bus.busy, bus.done}); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL midrst_done: got %0d want 0", done_cnt); end
        d = rand_word();
        exp_h = 1; clear_mon();
        send_req(d, 8'd0, 1'b1, 1'b0);
        wait_done(400, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL midrst_resend_timeout: got no done want done"); end
        check_frame("resend", d, 1);
    endtask

    task automatic test_div_max();
        logic [NB-1:0] d;
        bit to;
        d = rand_word();
        exp_h = 256; clear_mon();
        send_req(d, 8'hFF, 1'b1, 1'b0);
        wait_done(60000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL divmax_timeout: got no done want done"); end
        check_frame("divmax", d, 256);
    endtask

    initial begin
        test_reset();
        test_div0_single();
        test_random_frames();
        test_start_drst_together();
        test_drst();
        test_reset_mid();
        test_div_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
